ysyx_22050368_mdu: RTL and testbench

Parametrised iterative multiply/divide unit, the multi-cycle companion to the single-cycle integer ALU in the EX stage.
- Executes the RV64M op set, including the 32-bit "W" forms, over a generic XLEN datapath.
- Uses valid/ready handshakes on both sides.
- Supports pipeline flush.
- Reports divide-by-zero and signed-overflow flags alongside the result.

---
 rtl/ysyx_22050368_mdu_if.sv | 26 ++
 rtl/ysyx_22050368_mdu.sv | 170 +++++++++++++++++
 tb/tb_ysyx_22050368_mdu.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050368_mdu_if.sv
// Request/response handshake bundle between the EX stage and the iterative MDU.
interface ysyx_22050368_mdu_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [2:0]      mode;
    logic            word;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            div_zero_flag;
    logic            overflow_flag;

    modport master (
        output flush, in_valid, op1, op2, mode, word, out_ready,
        input  in_ready, out_valid, result, div_zero_flag, overflow_flag
    );
    modport slave (
        input  flush, in_valid, op1, op2, mode, word, out_ready,
        output in_ready, out_valid, result, div_zero_flag, overflow_flag
    );
endinterface

// File: rtl/ysyx_22050368_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Optional macro YSYX_22050368_MDU_EARLY_EN: zero-operand / small-dividend early finish.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | first cycle prepares operands, then one iteration per cycle
// DONE  | result and flags held until out_ready
module ysyx_22050368_mdu #(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    ysyx_22050368_mdu_if.slave bus
);
    localparam int SH = XLEN - WLEN;
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              state_q;
    logic                in_ready_q, out_valid_q, dz_q, ov_q;
    logic                first_q, skip_q, word_q;
    logic [2:0]          mode_q;
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     op1_q, op2_q, y_q, result_q;
    logic [2*XLEN-1:0]   x_q, acc_q;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
        return XLEN'($signed(x << SH) >>> SH);
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] x);
        return (x << SH) >> SH;
    endfunction

    function automatic logic [XLEN-1:0] fix_w(input logic w, input logic [XLEN-1:0] x);
        return w ? sext_w(x) : x;
    endfunction

    logic                is_div, sgn1, sgn2, neg1, neg2, rneg, dz, ov, early, ge;
    logic [2:0]          emode;
    logic [XLEN-1:0]     a, b, m1, m2, minv, spec_res, y_d, qr, prod_hi, fin_res;
    logic [XLEN:0]       trial;
    logic [2*XLEN-1:0]   acc_d, x_d;

    always_comb begin
        is_div = mode_q[2];
        // word-mode MULH* is illegal and behaves as word MUL
        emode  = (word_q && !is_div) ? 3'd0 : mode_q;
        sgn1   = (emode == 3'd1) || (emode == 3'd2) || (emode == 3'd4) || (emode == 3'd6);
        sgn2   = (emode == 3'd1) || (emode == 3'd4) || (emode == 3'd6);
        a      = word_q ? (sgn1 ? sext_w(op1_q) : zext_w(op1_q)) : op1_q;
        b      = word_q ? (sgn2 ? sext_w(op2_q) : zext_w(op2_q)) : op2_q;
        neg1   = sgn1 && a[XLEN-1];
        neg2   = sgn2 && b[XLEN-1];
        m1     = neg1 ? -a : a;
        m2     = neg2 ? -b : b;
        rneg   = (emode == 3'd6) ? neg1 : (neg1 ^ neg2);
        minv   = {XLEN{1'b1}} << (word_q ? WLEN - 1 : XLEN - 1);
        dz     = is_div && (b == '0);
        ov     = is_div && sgn1 && (b == '1) && (a == minv);
`ifdef YSYX_22050368_MDU_EARLY_EN
        early  = is_div ? (m1 < m2) : ((a == '0) || (b == '0));
`else
        early  = 1'b0;
`endif
        if (dz)          spec_res = mode_q[1] ? fix_w(word_q, a) : '1;
        else if (ov)     spec_res = mode_q[1] ? '0 : a;
        else if (is_div) spec_res = mode_q[1] ? fix_w(word_q, a) : '0;
        else             spec_res = '0;

        trial = {acc_q[XLEN-1:0], y_q[XLEN-1]};
        ge    = trial >= {1'b0, x_q[XLEN-1:0]};
        if (is_div) begin
            acc_d = {{XLEN{1'b0}}, (ge ? trial[XLEN-1:0] - x_q[XLEN-1:0] : trial[XLEN-1:0])};
            x_d   = x_q;
            y_d   = {y_q[XLEN-2:0], ge};
        end else begin
            acc_d = acc_q + (y_q[0] ? x_q : '0);
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
        end

        // high half of the two's-complement negated 2N-bit product
        prod_hi = rneg ? (~acc_d[2*XLEN-1:XLEN] + XLEN'(acc_d[XLEN-1:0] == '0))
                       : acc_d[2*XLEN-1:XLEN];
        qr = mode_q[1] ? acc_d[XLEN-1:0] : y_d;
        if (rneg) qr = -qr;
        if (is_div)              fin_res = fix_w(word_q, qr);
        else if (emode == 3'd0)  fin_res = fix_w(word_q, acc_d[XLEN-1:0]);
        else                     fin_res = prod_hi;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            first_q     <= 1'b0;
            skip_q      <= 1'b0;
            word_q      <= 1'b0;
            mode_q      <= '0;
            cnt_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
        end else if (bus.flush) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.in_valid) begin
                    op1_q      <= bus.op1;
                    op2_q      <= bus.op2;
                    mode_q     <= bus.mode;
                    word_q     <= bus.word && (SH != 0);
                    dz_q       <= 1'b0;
                    ov_q       <= 1'b0;
                    first_q    <= 1'b1;
                    in_ready_q <= 1'b0;
                    state_q    <= S_CALC;
                end
                S_CALC: if (first_q) begin
                    first_q  <= 1'b0;
                    dz_q     <= dz;
                    ov_q     <= ov;
                    skip_q   <= dz || ov || early;
                    result_q <= spec_res;
                    cnt_q    <= word_q ? CW'(WLEN) : CW'(XLEN);
                    acc_q    <= '0;
                    x_q      <= {{XLEN{1'b0}}, (is_div ? m2 : m1)};
                    // dividend is left-aligned so the next bit is always the MSB
                    y_q      <= is_div ? (word_q ? (m1 << SH) : m1) : m2;
                end else if (skip_q) begin
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
                end else begin
                    acc_q <= acc_d;
                    x_q   <= x_d;
                    y_q   <= y_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= fin_res;
                    end
                end
                S_DONE: if (bus.out_ready) begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.result        = result_q;
    assign bus.div_zero_flag = dz_q;
    assign bus.overflow_flag = ov_q;
endmodule

// File: tb/tb_ysyx_22050368_mdu.sv
// Randomised bench for the MDU against an arithmetic RV64M reference model,
// plus directed reset, flush, backpressure and XLEN=32 cases.
module tb_ysyx_22050368_mdu;
`ifdef YSYX_22050368_MDU_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ysyx_22050368_mdu_if #(.XLEN(64)) bus ();
    ysyx_22050368_mdu_if #(.XLEN(32)) bus32 ();

    ysyx_22050368_mdu #(.XLEN(64), .WLEN(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    ysyx_22050368_mdu #(.XLEN(32), .WLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    task automatic model(input logic [63:0] o1, input logic [63:0] o2, input logic [2:0] md,
                         input logic w, output logic [63:0] r, output logic dz,
                         output logic ov, output int lat);
        logic [127:0] p;
        logic [63:0]  a, b, ma, mb, minv;
        logic [31:0]  lo;
        logic         sgn, early;
        longint       sa, sb;
        dz = 1'b0; ov = 1'b0; early = 1'b0; r = '0;
        lat = (w ? 32 : 64) + 1;
        if (!md[2]) begin
            if (w) begin
                lo    = o1[31:0] * o2[31:0];
                r     = sx32(lo);
                early = (o1[31:0] == 32'd0) || (o2[31:0] == 32'd0);
            end else begin
                case (md)
                    3'd1:    p = {{64{o1[63]}}, o1} * {{64{o2[63]}}, o2};
                    3'd2:    p = {{64{o1[63]}}, o1} * {64'd0, o2};
                    default: p = {64'd0, o1} * {64'd0, o2};
                endcase
                r     = (md == 3'd0) ? p[63:0] : p[127:64];
                early = (o1 == 64'd0) || (o2 == 64'd0);
            end
        end else begin
            sgn  = !md[0];
            a    = w ? (sgn ? sx32(o1[31:0]) : {32'd0, o1[31:0]}) : o1;
            b    = w ? (sgn ? sx32(o2[31:0]) : {32'd0, o2[31:0]}) : o2;
            minv = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
            if (b == 64'd0) begin
                dz = 1'b1; lat = 2;
                r  = md[1] ? a : '1;
            end else if (sgn && b == '1 && a == minv) begin
                ov = 1'b1; lat = 2;
                r  = md[1] ? 64'd0 : a;
            end else begin
                if (sgn) begin
                    sa = a; sb = b;
                    r  = md[1] ? sa % sb : sa / sb;
                end else begin
                    r  = md[1] ? a % b : a / b;
                end
                ma    = (sgn && a[63]) ? -a : a;
                mb    = (sgn && b[63]) ? -b : b;
                early = ma < mb;
            end
            if (w) r = sx32(r[31:0]);
        end
        if (EARLY && early) lat = 2;
    endtask

    task automatic start_op(input logic [63:0] o1, input logic [63:0] o2,
                            input logic [2:0] md, input logic w);
        int t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        bus.op1 = o1; bus.op2 = o2; bus.mode = md; bus.word = w;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_op(input logic [63:0] er, input logic edz, input logic eov,
                             input int elat, input int hold);
        int lat = 0;
        while (!bus.out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(elat));
        chk("result", bus.result, er);
        chk("div_zero_flag", 64'(bus.div_zero_flag), 64'(edz));
        chk("overflow_flag", 64'(bus.overflow_flag), 64'(eov));
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk("held_valid", 64'(bus.out_valid), 64'd1);
            chk("held_result", bus.result, er);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("release", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    endtask

    task automatic run(input logic [63:0] o1, input logic [63:0] o2, input logic [2:0] md,
                       input logic w, input int hold);
        logic [63:0] er;
        logic        edz, eov;
        int          elat;
        model(o1, o2, md, w, er, edz, eov, elat);
        start_op(o1, o2, md, w);
        finish_op(er, edz, eov, elat, hold);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return {$urandom(), 32'h8000_0000};
            4:       return 64'($urandom_range(0, 20));
            5:       return sx32($urandom());
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        int          t;
        logic        seen;
        logic [63:0] o1, o2;
        bus.flush = 0; bus.in_valid = 0; bus.op1 = 0; bus.op2 = 0;
        bus.mode = 0; bus.word = 0; bus.out_ready = 0;
        bus32.flush = 0; bus32.in_valid = 0; bus32.op1 = 0; bus32.op2 = 0;
        bus32.mode = 0; bus32.word = 0; bus32.out_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        rst_n = 1'b1;

        run(-64'sd2, 64'd3, 3'd0, 1'b0, 0);
        run(-64'sd2, 64'd3, 3'd1, 1'b0, 0);
        run(64'h0000_0000_8000_0000, '1, 3'd4, 1'b1, 0);
        run(-64'sd9, 64'd0, 3'd6, 1'b0, 0);
        run(-64'sd9, 64'd0, 3'd5, 1'b0, 0);
        run(64'd17, 64'd5, 3'd7, 1'b0, 20);
        run('1, '1, 3'd3, 1'b0, 0);

        // reset in the middle of an iterative divide
        start_op(64'd100, 64'd7, 3'd5, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_result", bus.result, 64'd0);
        rst_n = 1'b1;
        run(64'd3, 64'd5, 3'd0, 1'b0, 0);

        // flush during a divide
        start_op(-64'sd100, 64'd7, 3'd4, 1'b0);
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            seen |= bus.out_valid;
            @(negedge clk);
        end
        chk("flush_no_valid", 64'(seen), 64'd0);

        // a request presented together with flush is dropped
        bus.op1 = 64'd9; bus.op2 = 64'd3; bus.mode = 3'd4; bus.word = 1'b0;
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_drop", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 60; i++) begin
            o1 = pick();
            o2 = pick();
            run(o1, o2, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
        end

        // XLEN == WLEN build: word flag has no effect
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus32.op1 = '1; bus32.op2 = '1; bus32.mode = 3'd3; bus32.word = k[0];
            bus32.in_valid = 1'b1;
            @(negedge clk);
            bus32.in_valid = 1'b0;
            t = 0;
            while (!bus32.out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk(k == 0 ? "mulhu32" : "mulhu32_word", 64'(bus32.result), 64'hFFFF_FFFE);
            bus32.out_ready = 1'b1;
            @(negedge clk);
            bus32.out_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
